// File: rtl/reg_bus_arbiter_if.sv
// Register-bus handshake bundle: SPI toggle-handshake write port and local valid/ready port.
// The arbiter connects through the slave modport, requesters through the master modport.
interface reg_bus_arbiter_if #(
    parameter int AW = 2
);
    logic          spi_req_tgl;
    logic [AW-1:0] spi_addr;
    logic [7:0]    spi_wdata;
    logic          spi_ack_tgl;

    logic          loc_valid;
    logic          loc_we;
    logic [AW-1:0] loc_addr;
    logic [7:0]    loc_wdata;
    logic          loc_ready;
    logic [7:0]    loc_rdata;
    logic          loc_rvalid;

    modport slave (
        input  spi_req_tgl, spi_addr, spi_wdata,
        input  loc_valid, loc_we, loc_addr, loc_wdata,
        output spi_ack_tgl, loc_ready, loc_rdata, loc_rvalid
    );

    modport master (
        output spi_req_tgl, spi_addr, spi_wdata,
        output loc_valid, loc_we, loc_addr, loc_wdata,
        input  spi_ack_tgl, loc_ready, loc_rdata, loc_rvalid
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Register file shared between an asynchronous SPI writer and a local clk-domain port.
// Define SPI_FIXED_PRIO_EN to let SPI win every collision instead of round-robin.
//
// state   | meaning
// IDLE    | waiting; arbitrates pending SPI write against local request
// SPI_WR  | commits held SPI write, toggles the ack
// LOC_ACC | commits local read/write, loc_ready high
module reg_bus_arbiter #(
    parameter int         NUM_REGS = 4,
    parameter int         AW       = 2,
    parameter logic [7:0] ID_VALUE = 8'h96
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reg_bus_arbiter_if.slave        bus,
    output logic [8*NUM_REGS-1:0]   regs_flat_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {IDLE, SPI_WR, LOC_ACC} state_t;

    state_t        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [AW-1:0] hold_addr_q;
    logic [7:0]    hold_wdata_q;
    logic          ack_q;
    logic          last_spi_q;
    logic [7:0]    rdata_q;
    logic          rvalid_q;
    logic [7:0]    regs_q [NUM_REGS];

    logic          spi_pend;
    logic          grant_spi, grant_loc, pick_spi;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    rd_data;

    assign spi_pend = s2_q ^ s3_q;

    always_comb begin
        state_d   = state_q;
        grant_spi = 1'b0;
        grant_loc = 1'b0;
        pick_spi  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = hold_addr_q;
        wr_data   = hold_wdata_q;
        case (state_q)
            IDLE: begin
                if (spi_pend && bus.loc_valid) begin
`ifdef SPI_FIXED_PRIO_EN
                    pick_spi = 1'b1;
`else
                    pick_spi = ~last_spi_q;
`endif
                    grant_spi = pick_spi;
                    grant_loc = ~pick_spi;
                end else begin
                    grant_spi = spi_pend;
                    grant_loc = bus.loc_valid;
                end
                if (grant_spi) begin
                    state_d = SPI_WR;
                end else if (grant_loc) begin
                    state_d = LOC_ACC;
                end
            end
            SPI_WR: begin
                wr_en   = 1'b1;
                state_d = IDLE;
            end
            LOC_ACC: begin
                wr_en   = bus.loc_we;
                wr_addr = bus.loc_addr;
                wr_data = bus.loc_wdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Unmapped addresses fall through to zero; reg 0 never matches a write below.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.loc_addr == AW'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= 8'h00;
            ack_q        <= 1'b0;
            last_spi_q   <= 1'b0;
            rdata_q      <= 8'h00;
            rvalid_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? ID_VALUE : 8'h00;
            end
        end else begin
            state_q <= state_d;
            s1_q    <= bus.spi_req_tgl;
            s2_q    <= s1_q;
            // spi_addr/spi_wdata are stable from the toggle edge until the ack
            if (grant_spi) begin
                s3_q         <= s2_q;
                hold_addr_q  <= bus.spi_addr;
                hold_wdata_q <= bus.spi_wdata;
            end
            if (state_q == SPI_WR) begin
                ack_q      <= ~ack_q;
                last_spi_q <= 1'b1;
            end
            if (state_q == LOC_ACC) begin
                last_spi_q <= 1'b0;
            end
            rvalid_q <= (state_q == LOC_ACC) && !bus.loc_we;
            if ((state_q == LOC_ACC) && !bus.loc_we) begin
                rdata_q <= rd_data;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat_o[8*g +: 8] = regs_q[g];
    end

    assign bus.spi_ack_tgl = ack_q;
    assign bus.loc_ready   = (state_q == LOC_ACC);
    assign bus.loc_rdata   = rdata_q;
    assign bus.loc_rvalid  = rvalid_q;
    assign busy_o          = (state_q != IDLE) || spi_pend;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter (NUM_REGS=3 so address 3 is unmapped).
// Expected handshake events are queued at stimulus time and popped by a negedge monitor.
module tb_reg_bus_arbiter;
    localparam int NR = 3;
    localparam int AW = 2;
    localparam int EV_ACK = 1;
    localparam int EV_RDY = 2;
    localparam int EV_RD  = 3;

    typedef struct {
        int          kind;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.AW(AW)) bus ();
    logic [8*NR-1:0] regs_flat;
    logic            busy;

    reg_bus_arbiter #(.NUM_REGS(NR), .AW(AW), .ID_VALUE(8'h96)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .regs_flat_o(regs_flat),
        .busy_o     (busy)
    );

    int   total = 0;
    int   bad   = 0;
    ev_t  exp_q[$];
    logic spi_tgl = 1'b0;
    logic prev_ack = 1'b0;
    logic [7:0] mdl [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*NR-1:0] mdl_flat();
        logic [8*NR-1:0] f;
        for (int i = 0; i < NR; i++) f[8*i +: 8] = mdl[i];
        return f;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < NR; i++) mdl[i] = (i == 0) ? 8'h96 : 8'h00;
    endtask

    task automatic mdl_write(input int addr, input logic [7:0] d);
        if (addr > 0 && addr < NR) mdl[addr] = d;
    endtask

    task automatic push(input int kind, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop(input int kind, input logic [31:0] obs);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", kind, 0);
        end else begin
            e = exp_q.pop_front();
            check("event_order", kind, e.kind);
            if (kind != EV_RDY) check("event_data", obs, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack = 1'b0;
        end else begin
            if (bus.spi_ack_tgl !== prev_ack) begin
                prev_ack = bus.spi_ack_tgl;
                pop(EV_ACK, 32'(regs_flat));
            end
            if (bus.loc_ready) pop(EV_RDY, 32'h0);
            if (bus.loc_rvalid) pop(EV_RD, 32'(bus.loc_rdata));
        end
    end

    task automatic spi_toggle(input logic [AW-1:0] addr, input logic [7:0] d);
        bus.spi_addr    = addr;
        bus.spi_wdata   = d;
        spi_tgl         = ~spi_tgl;
        bus.spi_req_tgl = spi_tgl;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (bus.spi_ack_tgl !== spi_tgl && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("spi_ack_tgl", bus.spi_ack_tgl, spi_tgl);
    endtask

    task automatic loc_drive(input logic we, input logic [AW-1:0] addr, input logic [7:0] d);
        bus.loc_valid = 1'b1;
        bus.loc_we    = we;
        bus.loc_addr  = addr;
        bus.loc_wdata = d;
    endtask

    task automatic loc_wait(output int n);
        logic we;
        we = bus.loc_we;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.loc_ready && n < 20);
        check("loc_ready_seen", bus.loc_ready, 1);
        @(posedge clk);
        #1 bus.loc_valid = 1'b0;
        @(negedge clk);
        check("loc_rvalid_next", bus.loc_rvalid, !we);
        check("loc_ready_pulse", bus.loc_ready, 0);
    endtask

    task automatic loc_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] d);
        int n;
        @(posedge clk);
        #1 loc_drive(we, addr, d);
        loc_wait(n);
        check("loc_ready_lat", n, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.spi_req_tgl = 1'b0;
        bus.spi_addr    = '0;
        bus.spi_wdata   = 8'h00;
        bus.loc_valid   = 1'b0;
        bus.loc_we      = 1'b0;
        bus.loc_addr    = '0;
        bus.loc_wdata   = 8'h00;
        mdl_reset();

        repeat (3) @(negedge clk);
        check("rst_regs", 32'(regs_flat), 32'h000096);
        check("rst_ack", bus.spi_ack_tgl, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", bus.loc_ready, 0);
        check("rst_rvalid", bus.loc_rvalid, 0);
        check("rst_rdata", bus.loc_rdata, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // uncontended SPI write: commit on the 4th edge after the toggle
        @(posedge clk);
        mdl_write(2, 8'h5A);
        push(EV_ACK, 32'(mdl_flat()));
        #1 spi_toggle(2'd2, 8'h5A);
        repeat (3) @(posedge clk);
        #1 check("spi_lat_early", regs_flat[23:16], 8'h00);
        check("spi_busy", busy, 1);
        @(posedge clk);
        #1 check("spi_lat_4th", regs_flat[23:16], 8'h5A);
        @(negedge clk);
        check("spi_ack_after", bus.spi_ack_tgl, 1);
        check("spi_busy_clear", busy, 0);

        // ID register read and ignored write
        push(EV_RDY, 0);
        push(EV_RD, 32'h96);
        loc_access(1'b0, 2'd0, 8'h00);
        push(EV_RDY, 0);
        loc_access(1'b1, 2'd0, 8'hFF);
        check("reg0_readonly", 32'(regs_flat), 32'(mdl_flat()));
        push(EV_RDY, 0);
        mdl_write(1, 8'h33);
        loc_access(1'b1, 2'd1, 8'h33);
        check("loc_write_reg1", 32'(regs_flat), 32'(mdl_flat()));
        push(EV_RDY, 0);
        push(EV_RD, 32'h33);
        loc_access(1'b0, 2'd1, 8'h00);

        // collision with last_grant = LOC: SPI first in both builds
        mdl_write(1, 8'h11);
        push(EV_ACK, 32'(mdl_flat()));
        push(EV_RDY, 0);
        mdl_write(1, 8'h22);
        @(posedge clk);
        #1 spi_toggle(2'd1, 8'h11);
        repeat (2) @(posedge clk);
        #1 loc_drive(1'b1, 2'd1, 8'h22);
        loc_wait(n);
        wait_ack();
        check("collide_loc_final", 32'(regs_flat), 32'(mdl_flat()));

        // set last_grant = SPI, then collide again
        mdl_write(2, 8'h77);
        push(EV_ACK, 32'(mdl_flat()));
        @(posedge clk);
        #1 spi_toggle(2'd2, 8'h77);
        wait_ack();
        repeat (2) @(posedge clk);
`ifdef SPI_FIXED_PRIO_EN
        mdl_write(2, 8'h44);
        push(EV_ACK, 32'(mdl_flat()));
        push(EV_RDY, 0);
        mdl_write(2, 8'h55);
`else
        push(EV_RDY, 0);
        mdl_write(2, 8'h55);
        mdl_write(2, 8'h44);
        push(EV_ACK, 32'(mdl_flat()));
`endif
        #1 spi_toggle(2'd2, 8'h44);
        repeat (2) @(posedge clk);
        #1 loc_drive(1'b1, 2'd2, 8'h55);
        loc_wait(n);
        wait_ack();
        repeat (2) @(negedge clk);
        check("collide_spi_final", 32'(regs_flat), 32'(mdl_flat()));

        // unmapped address and SPI write to the ID register
        push(EV_RDY, 0);
        push(EV_RD, 32'h00);
        loc_access(1'b0, 2'd3, 8'h00);
        push(EV_RDY, 0);
        loc_access(1'b1, 2'd3, 8'hAB);
        check("oob_write_ignored", 32'(regs_flat), 32'(mdl_flat()));
        push(EV_ACK, 32'(mdl_flat()));
        @(posedge clk);
        #1 spi_toggle(2'd0, 8'hEE);
        wait_ack();
        check("spi_reg0_ignored", 32'(regs_flat), 32'(mdl_flat()));

        // reset while in SPI_WR
        repeat (2) @(posedge clk);
        #1 spi_toggle(2'd1, 8'h99);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        spi_tgl = 1'b0;
        bus.spi_req_tgl = 1'b0;
        mdl_reset();
        @(negedge clk);
        check("midrst_regs", 32'(regs_flat), 32'(mdl_flat()));
        check("midrst_ack", bus.spi_ack_tgl, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("postrst_regs", 32'(regs_flat), 32'(mdl_flat()));
        check("postrst_ack", bus.spi_ack_tgl, 0);
        check("postrst_busy", busy, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
